// File: rtl/dev_icap_if.sv
// Register-file side of the input-capture unit: configuration in, capture results and interrupts out.
interface dev_icap_if #(
    parameter int TIMER_BITS = 16
) ();
    logic                  enable;
    logic [2:0]            clk_source;
    logic [1:0]            capture_mode;
    logic                  capture_ack;
    logic [TIMER_BITS-1:0] period;
    logic [TIMER_BITS-1:0] high_time;
    logic                  valid;
    logic                  overrun;
    logic                  int_capture;
    logic                  int_ovf;

    modport master (
        output enable, clk_source, capture_mode, capture_ack,
        input  period, high_time, valid, overrun, int_capture, int_ovf
    );

    modport slave (
        input  enable, clk_source, capture_mode, capture_ack,
        output period, high_time, valid, overrun, int_capture, int_ovf
    );
endinterface

// File: rtl/dev_icap.sv
// Input-capture unit: synchronises a pin, emits edge pulses, and measures period / high time
// in prescaled ticks with saturating counters and sticky valid/overrun flags.
module dev_icap #(
    parameter int TIMER_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      io_in,
    output logic      io_risen,
    output logic      io_fallen,
    dev_icap_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    io_s;
    logic                    io_d;
    logic [9:0]              div;
    logic                    tick;
    logic [1:0]              mode_q;
    logic [2:0]              src_q;
    logic                    cfg_change;
    logic                    run;
    logic                    start_edge;
    logic                    high_edge;
    logic [TIMER_BITS-1:0]   cnt;
    logic [TIMER_BITS:0]     cnt_sum;
    logic [TIMER_BITS-1:0]   cnt_sat;
    logic [TIMER_BITS-1:0]   hshadow;
    logic                    cnt_clr;
    logic                    cnt_run;
    logic                    do_capture;
    logic                    do_shadow;

    // Pin synchroniser and edge detector, active regardless of FSM state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            io_d   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_in};
            io_d   <= io_s;
        end
    end

    assign io_s      = sync_q[SYNC_STAGES-1];
    assign io_risen  = io_s & ~io_d;
    assign io_fallen = ~io_s & io_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            mode_q <= '0;
            src_q  <= '0;
        end else begin
            div    <= div + 10'd1;
            mode_q <= bus.capture_mode;
            src_q  <= bus.clk_source;
        end
    end

    always_comb begin
        tick = 1'b0;
        case (bus.clk_source)
            3'd1:    tick = 1'b1;
            3'd2:    tick = &div[2:0];
            3'd3:    tick = &div[5:0];
            3'd4:    tick = &div[7:0];
            3'd5:    tick = &div[9:0];
            default: tick = 1'b0;
        endcase
    end

    assign cfg_change = (bus.capture_mode != mode_q) || (bus.clk_source != src_q);
    assign run        = bus.enable && (bus.capture_mode != 2'd0);
    assign start_edge = (bus.capture_mode == 2'd2) ? io_fallen : io_risen;
    assign high_edge  = (bus.capture_mode == 2'd3) && io_fallen;

    // Saturating increment; the capture edge's own tick is included in the captured value
    assign cnt_sum = {1'b0, cnt} + {{TIMER_BITS{1'b0}}, tick};
    assign cnt_sat = cnt_sum[TIMER_BITS] ? '1 : cnt_sum[TIMER_BITS-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        cnt_run    = 1'b0;
        do_capture = 1'b0;
        do_shadow  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (run) state_nxt = ARM;
            end
            ARM: begin
                cnt_clr = 1'b1;
                if (!run)            state_nxt = IDLE;
                else if (cfg_change) state_nxt = ARM;
                else if (start_edge) state_nxt = MEAS;
            end
            MEAS: begin
                if (!run) begin
                    state_nxt = IDLE;
                    cnt_clr   = 1'b1;
                end else if (cfg_change) begin
                    state_nxt = ARM;
                    cnt_clr   = 1'b1;
                end else if (start_edge) begin
                    do_capture = 1'b1;
                end else begin
                    cnt_run   = 1'b1;
                    do_shadow = high_edge;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            hshadow <= '0;
        end else begin
            if (cnt_clr || do_capture) cnt <= '0;
            else if (cnt_run)          cnt <= cnt_sat;
            if (do_shadow)             hshadow <= cnt_sat;
        end
    end

    // Capture wins over a coincident ack: valid stays set, overrun is cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.period      <= '0;
            bus.high_time   <= '0;
            bus.valid       <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.int_capture <= 1'b0;
            bus.int_ovf     <= 1'b0;
        end else begin
            bus.int_capture <= do_capture;
            bus.int_ovf     <= do_capture && (&cnt_sat);
            if (do_capture) begin
                bus.period  <= cnt_sat;
                if (bus.capture_mode == 2'd3) bus.high_time <= hshadow;
                bus.valid   <= 1'b1;
                bus.overrun <= bus.valid && !bus.capture_ack;
            end else if (bus.capture_ack) begin
                bus.valid   <= 1'b0;
                bus.overrun <= 1'b0;
            end
        end
    end

endmodule
